// File: rtl/bcd_pkg.sv
// Shared definitions for the decade counter: digit type, limits and the next-state function.
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   // Codes above the terminal count (including illegal 10..15) go straight to 0.
   function automatic bcd_digit_t bcd_inc(bcd_digit_t d, bcd_digit_t max = BCD_MAX);
      if (d >= max) return '0;
      else          return d + 4'd1;
   endfunction
endpackage

// File: rtl/bcd.sv
// Free-running single-digit BCD counter: 0..MAX_VALUE then wraps to 0, async active-high reset.
module bcd
   import bcd_pkg::*;
#(
   parameter logic [BCD_W-1:0] RESET_VALUE = 4'd0,
   parameter logic [BCD_W-1:0] MAX_VALUE   = 4'd9
) (
   input  logic             clk,
   input  logic             reset,
   output logic [BCD_W-1:0] count
);

   generate
      if (MAX_VALUE < 4'd1 || MAX_VALUE > BCD_MAX) begin : g_bad_max
         $error("bcd: MAX_VALUE must be in 1..9");
      end
      if (RESET_VALUE > MAX_VALUE) begin : g_bad_rst
         $error("bcd: RESET_VALUE must not exceed MAX_VALUE");
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count <= RESET_VALUE;
      else       count <= bcd_inc(count, MAX_VALUE);
   end

endmodule

// File: tb/tb_bcd.sv
// Directed bench for bcd: default decade counter plus a MAX_VALUE=5 variant on the same clock/reset.
module tb_bcd;
   logic       clk;
   logic       reset;
   logic [3:0] count;
   logic [3:0] count5;
   int checks = 0;
   int errors = 0;

   bcd dut (.clk(clk), .reset(reset), .count(count));
   bcd #(.RESET_VALUE(4'd0), .MAX_VALUE(4'd5)) dut5 (.clk(clk), .reset(reset), .count(count5));

   initial clk = 1'b0;
   always #25 clk = ~clk;

   task automatic test_reset;
      reset = 1'b1;
      #1;
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL reset_async: count=%0d expected 0", count); end
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL reset_edge: count=%0d expected 0", count); end
      checks++;
      if (count5 !== 4'd0) begin errors++; $display("FAIL reset_edge5: count5=%0d expected 0", count5); end
      #24;
      reset = 1'b0;
   endtask

   task automatic test_free_count;
      logic [3:0] exp_tbl [12] = '{4'd1,4'd2,4'd3,4'd4,4'd5,4'd6,4'd7,4'd8,4'd9,4'd0,4'd1,4'd2};
      logic [3:0] exp5_tbl[12] = '{4'd1,4'd2,4'd3,4'd4,4'd5,4'd0,4'd1,4'd2,4'd3,4'd4,4'd5,4'd0};
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         checks++;
         if (count !== exp_tbl[i]) begin
            errors++; $display("FAIL free_count[%0d]: count=%0d expected %0d", i, count, exp_tbl[i]);
         end
         checks++;
         if (count5 !== exp5_tbl[i]) begin
            errors++; $display("FAIL free_count5[%0d]: count5=%0d expected %0d", i, count5, exp5_tbl[i]);
         end
      end
   endtask

   // Continues from the state left by test_free_count (dut=2, dut5=0).
   task automatic test_wrap;
      logic [3:0] exp  = 4'd2;
      logic [3:0] exp5 = 4'd0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         exp  = (exp  == 4'd9) ? 4'd0 : exp  + 4'd1;
         exp5 = (exp5 == 4'd5) ? 4'd0 : exp5 + 4'd1;
         checks++;
         if (count !== exp || count > 4'd9) begin
            errors++; $display("FAIL wrap[%0d]: count=%0d expected %0d", i, count, exp);
         end
         checks++;
         if (count5 !== exp5) begin
            errors++; $display("FAIL wrap5[%0d]: count5=%0d expected %0d", i, count5, exp5);
         end
      end
   endtask

   task automatic test_async_reset;
      int n = 0;
      while (count !== 4'd6 && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (count !== 4'd6) begin errors++; $display("FAIL reach_six: count=%0d expected 6", count); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL async_mid: count=%0d expected 0", count); end
      checks++;
      if (count5 !== 4'd0) begin errors++; $display("FAIL async_mid5: count5=%0d expected 0", count5); end
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL async_hold: count=%0d expected 0", count); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd1) begin errors++; $display("FAIL async_release: count=%0d expected 1", count); end
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd2) begin errors++; $display("FAIL async_second: count=%0d expected 2", count); end
   endtask

   task automatic test_illegal;
      @(negedge clk);
      force dut.count = 4'd12;
      #1;
      release dut.count;
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL illegal_recover: count=%0d expected 0", count); end
      @(posedge clk); #1;
      checks++;
      if (count !== 4'd1) begin errors++; $display("FAIL illegal_next: count=%0d expected 1", count); end
   endtask

   task automatic test_param;
      logic [3:0] exp5_tbl[13] = '{4'd1,4'd2,4'd3,4'd4,4'd5,4'd0,4'd1,4'd2,4'd3,4'd4,4'd5,4'd0,4'd1};
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (count5 !== 4'd0) begin errors++; $display("FAIL param_reset: count5=%0d expected 0", count5); end
      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         checks++;
         if (count5 !== exp5_tbl[i]) begin
            errors++; $display("FAIL param_seq[%0d]: count5=%0d expected %0d", i, count5, exp5_tbl[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_free_count();
      test_wrap();
      test_async_reset();
      test_illegal();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
